tt_adder_exerciser: RTL and testbench
=====================================

Name: tt_adder_exerciser

Overview:
- On-chip initiator for the 8-bit operand/sum interface of the user-design adder.
- Drives pseudo-random operand pairs on op_a/op_b and samples the returned sum_in after a fixed settle latency.
- Compares each sample against (op_a + op_b) mod 256 and reports vector count, error count and pass/fail.
- Used as a built-in self-test at bring-up, sitting between the pin mux and the adder core.

Parameters:
- SEED, 16'hACE1, initial LFSR state; a value of 0 is replaced by 16'h0001.
- NUM_VEC, 16, vectors per run; legal range 1..255.
- LATENCY, 0, extra settle cycles between operand update and sum sampling; legal range 0..15.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  single-cycle request to begin a run.
- busy  output  1  high while a run is in progress.
- done  output  1  high from run completion until the next accepted start or rst.
- op_a  output  8  operand A to the adder; registered.
- op_b  output  8  operand B to the adder; registered.
- sum_in  input  8  sum returned by the adder.
- vec_count  output  8  vectors checked in the current run.
- err_count  output  8  mismatches in the current run; saturates at 255.
- pass  output  1  valid while done is high; 1 if err_count == 0.

Behaviour:
- Reset: state IDLE, LFSR = SEED (or 1 if SEED is 0), and every output = 0.
- Reset mid-run aborts the run immediately with the same result. No partial results are kept.
- FSM states:
  - IDLE: start=1 → LOAD. Clears vec_count and err_count, reloads the LFSR from SEED, and sets busy=1.
  - LOAD (1 cycle): op_a ← lfsr[15:8], op_b ← lfsr[7:0]. Goes to SETTLE if LATENCY > 0, else to CHECK. The settle counter is loaded with LATENCY.
  - SETTLE: counter decrements each cycle. When it reaches 1 → CHECK. op_a and op_b are held.
  - CHECK (1 cycle):
    - Samples sum_in and compares it with (op_a + op_b)[7:0]; the carry is discarded.
    - On mismatch, err_count increments, saturating at 255.
    - vec_count increments and the LFSR advances one step.
    - If the new vec_count == NUM_VEC → DONE, else → LOAD.
  - DONE: busy=0, done=1, pass = (err_count == 0). start=1 behaves as in IDLE (reload and rerun). op_a and op_b hold their last values.
- Vector period is LATENCY+2 cycles. sum_in is sampled LATENCY+1 cycles after op_a/op_b change.
- done rises NUM_VEC*(LATENCY+2) cycles after the start-accept edge.
- start while busy=1 is ignored.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1 (mask 16'hB400). Shift right; when the LSB is 1, XOR with the mask. It never reaches 0.
- op_a and op_b never change outside LOAD.

Optional Feature:
- Macro: TT_ADDER_EXERCISER_FAILCAPTURE_EN.
- When defined:
  - Adds outputs fail_a[7:0], fail_b[7:0], fail_sum[7:0] and fail_idx[7:0].
  - These latch op_a, op_b, sum_in and vec_count at the first mismatch of a run, and hold until the next start or rst.
  - All are 0 if the run has no failure.
- When not defined: these ports and their registers do not exist, and the remaining behaviour is identical.

Decomposition:
- Shared package tt_adder_pkg contains:
  - the state enum (IDLE, LOAD, SETTLE, CHECK, DONE);
  - the LFSR_MASK constant 16'hB400;
  - DATA_W = 8.
- Sub-module tt_lfsr16 (ports: clk, rst, load, seed, step, state) is natural and reusable for other self-test blocks.

Test Plan:
- Ideal adder (sum_in = op_a+op_b), SEED=16'hACE1, NUM_VEC=4, LATENCY=0; pulse start → first op_a=8'hAC, op_b=8'hE1; done after 8 cycles; vec_count=4, err_count=0, pass=1.
- Same setup, but sum_in forced to op_a+op_b+1 on the 2nd vector only → err_count=1, pass=0; with FAILCAPTURE_EN, fail_idx=1 and fail_sum = expected+1.
- LATENCY=3, adder model with 4-cycle registered delay, NUM_VEC=16 → done after 80 cycles, pass=1; the same model with LATENCY=2 → err_count>0.
- start pulsed at cycles 2 and 5 of a run → second pulse ignored; run completes normally; a start in DONE reruns with the identical operand sequence.
- rst asserted during SETTLE → next cycle busy=0, done=0, op_a=op_b=0, counts=0; a following start yields the same sequence as from reset.
- Stuck-at-zero sum_in, NUM_VEC=255 → err_count=255 (saturated, no wrap), pass=0.

Source files
------------

// File: rtl/tt_adder_pkg.sv
// Shared constants for the adder exerciser: datapath width, LFSR taps, FSM state codes
// and the seed sanitiser.
package tt_adder_pkg;

  localparam int DATA_W = 8;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef logic [2:0] state_t;
  localparam state_t IDLE   = 3'd0;
  localparam state_t LOAD   = 3'd1;
  localparam state_t SETTLE = 3'd2;
  localparam state_t CHECK  = 3'd3;
  localparam state_t DONE   = 3'd4;

  // An all-zero Galois LFSR would lock up, so a zero seed is replaced by 1.
  function automatic logic [15:0] lfsr_seed(input logic [15:0] seed);
    return (seed == 16'h0000) ? 16'h0001 : seed;
  endfunction

endpackage

// File: rtl/tt_lfsr16.sv
// 16-bit right-shifting Galois LFSR (x^16+x^14+x^13+x^11+1) with synchronous
// reload from a seed; reusable by other self-test blocks.
module tt_lfsr16
  import tt_adder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst || load) begin
      state <= lfsr_seed(seed);
    end else if (step) begin
      state <= state[0] ? ((state >> 1) ^ LFSR_MASK) : (state >> 1);
    end
  end

endmodule

// File: rtl/tt_adder_exerciser.sv
// Built-in self-test initiator for the 8-bit adder: drives LFSR operand pairs and checks
// the returned sum. Optional first-failure capture: define TT_ADDER_EXERCISER_FAILCAPTURE_EN.
module tt_adder_exerciser
  import tt_adder_pkg::*;
#(
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int          NUM_VEC = 16,
  parameter int          LATENCY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  input  logic [DATA_W-1:0] sum_in,
  output logic [DATA_W-1:0] vec_count,
  output logic [DATA_W-1:0] err_count,
  output logic              pass
`ifdef TT_ADDER_EXERCISER_FAILCAPTURE_EN
  ,
  output logic [DATA_W-1:0] fail_a,
  output logic [DATA_W-1:0] fail_b,
  output logic [DATA_W-1:0] fail_sum,
  output logic [DATA_W-1:0] fail_idx
`endif
);

  state_t              state;
  logic [3:0]          settle_cnt;
  logic [15:0]         lfsr;
  logic                accept;
  logic                mismatch;
  logic [DATA_W-1:0]   sum_exp;
  logic [DATA_W-1:0]   vec_next;
  logic [DATA_W-1:0]   err_next;

  assign accept = start && ((state == IDLE) || (state == DONE));

  tt_lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .seed  (SEED),
    .step  (state == CHECK),
    .state (lfsr)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    sum_exp  = op_a + op_b;
    mismatch = (sum_in != sum_exp);
    vec_next = vec_count + 8'd1;
    err_next = err_count;
    if (mismatch && (err_count != 8'hFF)) begin
      err_next = err_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      vec_count  <= '0;
      err_count  <= '0;
`ifdef TT_ADDER_EXERCISER_FAILCAPTURE_EN
      fail_a     <= '0;
      fail_b     <= '0;
      fail_sum   <= '0;
      fail_idx   <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= LOAD;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            vec_count <= '0;
            err_count <= '0;
`ifdef TT_ADDER_EXERCISER_FAILCAPTURE_EN
            fail_a    <= '0;
            fail_b    <= '0;
            fail_sum  <= '0;
            fail_idx  <= '0;
`endif
          end
        end
        LOAD: begin
          op_a       <= lfsr[15:8];
          op_b       <= lfsr[7:0];
          settle_cnt <= 4'(LATENCY);
          state      <= (LATENCY > 0) ? SETTLE : CHECK;
        end
        SETTLE: begin
          settle_cnt <= settle_cnt - 4'd1;
          if (settle_cnt == 4'd1) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          vec_count <= vec_next;
          err_count <= err_next;
`ifdef TT_ADDER_EXERCISER_FAILCAPTURE_EN
          // err_count is still zero only until the first mismatch of the run.
          if (mismatch && (err_count == 8'd0)) begin
            fail_a   <= op_a;
            fail_b   <= op_b;
            fail_sum <= sum_in;
            fail_idx <= vec_count;
          end
`endif
          if (vec_next == 8'(NUM_VEC)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 8'd0);
          end else begin
            state <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_adder_exerciser.sv
// Self-checking bench: four exerciser instances against ideal, fault-injecting,
// lagging and stuck-at-zero adder models, with a sequence/error reference model.
module tb_tt_adder_exerciser;

  localparam int NI = 4;
  localparam int          NV  [NI] = '{4, 16, 16, 255};
  localparam int          LAT [NI] = '{0, 3, 2, 0};
  localparam logic [15:0] SD  [NI] = '{16'hACE1, 16'hACE1, 16'h1234, 16'h0000};

  logic       clk = 1'b0;
  logic       rst;
  logic       start     [NI];
  logic       busy      [NI];
  logic       done      [NI];
  logic       pass      [NI];
  logic [7:0] op_a      [NI];
  logic [7:0] op_b      [NI];
  logic [7:0] sum_in    [NI];
  logic [7:0] vec_count [NI];
  logic [7:0] err_count [NI];
`ifdef TT_ADDER_EXERCISER_FAILCAPTURE_EN
  logic [7:0] fail_a    [NI];
  logic [7:0] fail_b    [NI];
  logic [7:0] fail_sum  [NI];
  logic [7:0] fail_idx  [NI];
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [255:0] err_mask;
  logic [7:0]   pipe1 [3];
  logic [7:0]   pipe2 [3];
  logic [7:0]   prev_a [NI];
  logic [7:0]   prev_b [NI];

  initial forever #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    tt_adder_exerciser #(
      .SEED    (SD[g]),
      .NUM_VEC (NV[g]),
      .LATENCY (LAT[g])
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .op_a      (op_a[g]),
      .op_b      (op_b[g]),
      .sum_in    (sum_in[g]),
      .vec_count (vec_count[g]),
      .err_count (err_count[g]),
      .pass      (pass[g])
`ifdef TT_ADDER_EXERCISER_FAILCAPTURE_EN
      ,
      .fail_a    (fail_a[g]),
      .fail_b    (fail_b[g]),
      .fail_sum  (fail_sum[g]),
      .fail_idx  (fail_idx[g])
`endif
    );
  end

  // Adder models: 0 = ideal with per-vector +1 fault injection, 1/2 = result valid
  // four cycles after the operands change, 3 = output stuck at zero.
  assign sum_in[0] = op_a[0] + op_b[0] + {7'd0, err_mask[vec_count[0]]};
  always @(posedge clk) begin
    pipe1[0] <= op_a[1] + op_b[1];
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
    pipe2[0] <= op_a[2] + op_b[2];
    pipe2[1] <= pipe2[0];
    pipe2[2] <= pipe2[1];
  end
  assign sum_in[1] = pipe1[2];
  assign sum_in[2] = pipe2[2];
  assign sum_in[3] = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  task automatic check_cleared(input int k, input string tag);
    check({tag, "_busy"}, busy[k], 0);
    check({tag, "_done"}, done[k], 0);
    check({tag, "_pass"}, pass[k], 0);
    check({tag, "_ops"}, {op_a[k], op_b[k]}, 0);
    check({tag, "_counts"}, {vec_count[k], err_count[k]}, 0);
  endtask

  // Runs instance k once. extra_starts pulses start mid-run; rst_at > 0 resets the
  // design at that cycle of the run and checks the aborted state instead of results.
  task automatic run(input int k, input bit extra_starts, input int rst_at);
    logic [7:0]  ea[$];
    logic [7:0]  eb[$];
    logic [15:0] s;
    logic [7:0]  good, seen;
    int per, total, n, idx, exp_err, first_idx;

    per   = LAT[k] + 2;
    total = NV[k] * per;
    s = (SD[k] == 16'h0000) ? 16'h0001 : SD[k];
    for (int i = 0; i < NV[k]; i++) begin
      ea.push_back(s[15:8]);
      eb.push_back(s[7:0]);
      s = lfsr_next(s);
    end

    exp_err   = 0;
    first_idx = -1;
    for (int i = 0; i < NV[k]; i++) begin
      good = ea[i] + eb[i];
      case (k)
        0:       seen = err_mask[i] ? good + 8'd1 : good;
        1:       seen = good;
        2:       seen = (i == 0) ? prev_a[k] + prev_b[k] : ea[i-1] + eb[i-1];
        default: seen = 8'h00;
      endcase
      if (seen != good) begin
        if (first_idx < 0) first_idx = i;
        exp_err++;
      end
    end
    if (exp_err > 255) exp_err = 255;

    @(negedge clk) start[k] = 1'b1;
    @(negedge clk) start[k] = 1'b0;
    check("busy_after_start", busy[k], 1);
    check("done_low_after_start", done[k], 0);

    n = 0;
    while (!done[k] && n < total + 20) begin
      @(negedge clk);
      n++;
      if (extra_starts) start[k] = (n == 2 || n == 5);
      if (n <= total) begin
        idx = (n - 1) / per;
        check(((n - 1) % per == 0) ? "op_load" : "op_hold",
              {op_a[k], op_b[k]}, {ea[idx], eb[idx]});
      end
      if (n == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_cleared(k, "abort");
        for (int j = 0; j < NI; j++) begin
          prev_a[j] = 8'h00;
          prev_b[j] = 8'h00;
        end
        return;
      end
    end
    start[k] = 1'b0;

    check("done_latency", n, total);
    check("busy_at_done", busy[k], 0);
    check("vec_count", vec_count[k], NV[k]);
    check("err_count", err_count[k], exp_err);
    check("pass", pass[k], (exp_err == 0));
`ifdef TT_ADDER_EXERCISER_FAILCAPTURE_EN
    if (k == 0) begin
      if (first_idx < 0) begin
        check("fail_capture_clear", {fail_a[k], fail_b[k], fail_sum[k], fail_idx[k]}, 0);
      end else begin
        good = ea[first_idx] + eb[first_idx];
        check("fail_a", fail_a[k], ea[first_idx]);
        check("fail_b", fail_b[k], eb[first_idx]);
        check("fail_sum", fail_sum[k], good + 8'd1);
        check("fail_idx", fail_idx[k], first_idx);
      end
    end
`endif
    repeat (3) @(negedge clk);
    check("done_held", {done[k], pass[k], busy[k]}, {1'b1, (exp_err == 0), 1'b0});
    check("ops_held_in_done", {op_a[k], op_b[k]}, {ea[NV[k]-1], eb[NV[k]-1]});
    prev_a[k] = ea[NV[k]-1];
    prev_b[k] = eb[NV[k]-1];
  endtask

  initial begin
    rst      = 1'b1;
    err_mask = '0;
    for (int j = 0; j < NI; j++) begin
      start[j]  = 1'b0;
      prev_a[j] = 8'h00;
      prev_b[j] = 8'h00;
    end
    repeat (6) @(negedge clk);
    for (int j = 0; j < NI; j++) check_cleared(j, "reset");
    rst = 1'b0;
    @(negedge clk);

    run(0, 1'b0, -1);                      // ideal adder, 4 vectors
    err_mask = 256'h2;
    run(0, 1'b0, -1);                      // fault on the 2nd vector only
    err_mask = '0;
    run(0, 1'b1, -1);                      // starts while busy are ignored
    run(0, 1'b0, -1);                      // rerun from DONE repeats the sequence
    repeat (4) begin
      err_mask = 256'($urandom_range(0, 15));
      run(0, 1'b0, -1);
    end

    run(1, 1'b0, 1 + 5 * $urandom_range(0, 15) + $urandom_range(0, 2));  // reset in SETTLE
    repeat (3) @(negedge clk);
    run(1, 1'b0, -1);                      // latency matches adder delay
    run(2, 1'b0, -1);                      // latency one short of adder delay
    run(3, 1'b0, -1);                      // stuck-at-zero, 255 vectors, zero seed

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
